// File: rtl/servo_pkg.sv
// servo_pkg: shared defaults, state encoding and clamp helper for the servo PWM generator.
package servo_pkg;
  localparam int DEF_CLKS_PER_US = 50;
  localparam int DEF_PERIOD_US = 20000;
  localparam int DEF_MIN_US = 1000;
  localparam int DEF_MAX_US = 2000;
  localparam int DEF_CENTER_US = 1500;
  localparam int DEF_SLEW_US = 10;
  typedef enum logic {IDLE, RUN} state_t;
  function automatic logic [15:0] clamp16(input logic [15:0] v, input logic [15:0] lo, input logic [15:0] hi);
    return v < lo ? lo : (v > hi ? hi : v);
  endfunction
endpackage

// File: rtl/servo_us_tick.sv
// servo_us_tick: prescaler giving a one-cycle tick every CLKS_PER_US clocks, with synchronous clear.
module servo_us_tick
  import servo_pkg::*;
#(
  parameter int CLKS_PER_US = DEF_CLKS_PER_US
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  output logic tick
);
  localparam int W = CLKS_PER_US > 1 ? $clog2(CLKS_PER_US) : 1;
  logic [W-1:0] pre_cnt;
  assign tick = pre_cnt == W'(CLKS_PER_US - 1);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) pre_cnt <= '0;
    else pre_cnt <= (clr || tick) ? '0 : pre_cnt + 1'b1;
endmodule

// File: rtl/servo_pwm_gen.sv
// servo_pwm_gen: fixed-period servo PWM with clamped width latched at frame boundaries.
// Optional per-frame slew limiting is built when SERVO_PWM_SLEW_EN is defined.
module servo_pwm_gen
  import servo_pkg::*;
#(
  parameter int CLKS_PER_US = DEF_CLKS_PER_US,
  parameter int PERIOD_US = DEF_PERIOD_US,
  parameter int MIN_US = DEF_MIN_US,
  parameter int MAX_US = DEF_MAX_US,
  parameter int CENTER_US = DEF_CENTER_US,
  parameter int SLEW_US = DEF_SLEW_US
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [15:0] pulse_us,
  output logic        servo_out,
  output logic        frame_start,
  output logic [15:0] width_us,
  output logic        clamped
);
`ifdef SERVO_PWM_SLEW_EN
  localparam bit SLEW_EN = 1'b1;
`else
  localparam bit SLEW_EN = 1'b0;
`endif
  // Without slew limiting the step is unbounded, so the width jumps straight to target.
  localparam logic [15:0] STEP = SLEW_EN ? 16'(SLEW_US) : 16'hffff;
  state_t state, state_next;
  logic tick, boundary;
  logic [15:0] us_cnt, us_next, target, diff, width_next, width_new;
  servo_us_tick #(.CLKS_PER_US(CLKS_PER_US)) u_tick (
    .clk(clk),
    .reset_n(reset_n),
    .clr(!enable || boundary),
    .tick(tick)
  );
  always_comb begin
    state_next = enable ? RUN : IDLE;
    boundary = enable && (state == IDLE || (tick && us_cnt == 16'(PERIOD_US - 1)));
    target = clamp16(pulse_us, 16'(MIN_US), 16'(MAX_US));
    diff = target > width_us ? target - width_us : width_us - target;
    width_next = diff <= STEP ? target : (target > width_us ? width_us + STEP : width_us - STEP);
    width_new = boundary ? width_next : width_us;
    us_next = boundary ? '0 : us_cnt + 16'(tick);
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_next;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      servo_out <= 1'b0;
      frame_start <= 1'b0;
      width_us <= 16'(CENTER_US);
      clamped <= 1'b0;
      us_cnt <= '0;
    end else begin
      frame_start <= boundary;
      us_cnt <= enable ? us_next : '0;
      servo_out <= enable && us_next < width_new;
      width_us <= width_new;
      if (boundary) clamped <= pulse_us < 16'(MIN_US) || pulse_us > 16'(MAX_US);
    end
endmodule
